cordic_angle_prenorm: RTL and testbench

Upstream pre-stage for cordic_rotation. It accepts an arbitrary signed Q8.24 angle and a start vector (x, y), reduces the angle modulo 2π, and folds it into the CORDIC convergence range [-π/2, π/2]. Where the fold needs a π pre-rotation, it negates (x, y). Its outputs drive the x_in/y_in/angle_in inputs of cordic_rotation, and its done pulse qualifies them.

---
 rtl/cordic_angle_prenorm.sv | 121 ++++++++++++
 tb/tb_cordic_angle_prenorm.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cordic_angle_prenorm.sv
// Angle pre-stage for cordic_rotation. Reduces a signed Q8.24 angle modulo 2*pi and folds it
// into [-pi/2, pi/2], applying a pi pre-rotation to (x, y) by negation when needed.
module cordic_angle_prenorm #(
    parameter int                     n    = 32,
    parameter logic signed [n-1:0]    PI_Q = 52707179
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                start,
    input  logic signed [n-1:0] x_in,
    input  logic signed [n-1:0] y_in,
    input  logic signed [n-1:0] angle_in,
    output logic signed [n-1:0] x_out,
    output logic signed [n-1:0] y_out,
    output logic signed [n-1:0] angle_out,
    output logic [1:0]          quadrant,
    output logic                busy,
    output logic                done
);

    localparam int AW = n + 3;
    localparam logic signed [AW-1:0] PI_W         = {{3{PI_Q[n-1]}}, PI_Q};
    localparam logic signed [AW-1:0] TWO_PI_W     = PI_W <<< 1;
    localparam logic signed [AW-1:0] HALF_PI_W    = PI_W >>> 1;
    localparam logic signed [AW-1:0] THREE_HALF_W = PI_W + HALF_PI_W;
    localparam logic signed [AW-1:0] WRAP_W       = TWO_PI_W <<< 5;
    localparam logic signed [AW-1:0] ZERO_W       = '0;
    localparam logic signed [n-1:0]  TWO_PI_N     = TWO_PI_W[n-1:0];
    localparam logic signed [n-1:0]  MAX_N        = {1'b0, {(n-1){1'b1}}};
    localparam logic signed [n-1:0]  MIN_N        = {1'b1, {(n-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, REDUCE, FOLD} state_t;

    state_t               state_q;
    logic signed [AW-1:0] a_q;
    logic [2:0]           k_q;
    logic signed [n-1:0]  x_q, y_q;
    logic signed [n-1:0]  x_out_q, y_out_q, angle_out_q;
    logic [1:0]           quadrant_q;
    logic                 done_q;

    logic signed [AW-1:0] a_init_d, lim_d, a_red_d;
    logic signed [n-1:0]  ang_pi_d, ang_2pi_d, x_neg_d, y_neg_d;

    // Negative angles are lifted by 32*2pi so the binary-weighted subtraction only ever has to remove multiples.
    always_comb begin
        a_init_d  = {{3{angle_in[n-1]}}, angle_in} + (angle_in[n-1] ? WRAP_W : ZERO_W);
        lim_d     = TWO_PI_W <<< k_q;
        a_red_d   = (a_q >= lim_d) ? (a_q - lim_d) : a_q;
        ang_pi_d  = a_q[n-1:0] - PI_Q;
        ang_2pi_d = a_q[n-1:0] - TWO_PI_N;
        x_neg_d   = (x_q == MIN_N) ? MAX_N : -x_q;
        y_neg_d   = (y_q == MIN_N) ? MAX_N : -y_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            k_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            angle_out_q <= '0;
            quadrant_q  <= '0;
            done_q      <= 1'b0;
        end else if (enable) begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x_q     <= x_in;
                        y_q     <= y_in;
                        a_q     <= a_init_d;
                        k_q     <= 3'd5;
                        state_q <= REDUCE;
                    end
                end
                REDUCE: begin
                    a_q <= a_red_d;
                    if (k_q == 3'd0) begin
                        state_q <= FOLD;
                    end else begin
                        k_q <= k_q - 3'd1;
                    end
                end
                FOLD: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                    if (a_q <= HALF_PI_W) begin
                        angle_out_q <= a_q[n-1:0];
                        x_out_q     <= x_q;
                        y_out_q     <= y_q;
                        quadrant_q  <= 2'd0;
                    end else if (a_q < THREE_HALF_W) begin
                        angle_out_q <= ang_pi_d;
                        x_out_q     <= x_neg_d;
                        y_out_q     <= y_neg_d;
                        quadrant_q  <= 2'd1;
                    end else begin
                        angle_out_q <= ang_2pi_d;
                        x_out_q     <= x_q;
                        y_out_q     <= y_q;
                        quadrant_q  <= 2'd2;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign x_out     = x_out_q;
    assign y_out     = y_out_q;
    assign angle_out = angle_out_q;
    assign quadrant  = quadrant_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cordic_angle_prenorm.sv
// Bench for cordic_angle_prenorm: directed and random jobs against a modulo-arithmetic model,
// plus start-while-busy, enable stall, back-to-back and mid-job reset scenarios.
module tb_cordic_angle_prenorm;

    localparam longint PI    = 52707179;
    localparam longint TWO   = 2 * PI;
    localparam longint HALF  = PI / 2;
    localparam longint THALF = PI + HALF;
    localparam logic signed [31:0] MIN32 = 32'sh8000_0000;

    logic clock = 1'b0;
    logic reset, enable, start;
    logic signed [31:0] x_in, y_in, angle_in;
    logic signed [31:0] x_out, y_out, angle_out;
    logic [1:0] quadrant;
    logic busy, done;

    int n_checks = 0;
    int n_errors = 0;
    logic [97:0] exp_q[$];

    cordic_angle_prenorm dut (
        .clock(clock), .reset(reset), .enable(enable), .start(start),
        .x_in(x_in), .y_in(y_in), .angle_in(angle_in),
        .x_out(x_out), .y_out(y_out), .angle_out(angle_out),
        .quadrant(quadrant), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [31:0] sat_neg(input logic signed [31:0] v);
        return (v == MIN32) ? 32'sh7fff_ffff : -v;
    endfunction

    // Packed as {quadrant, angle, y, x}.
    function automatic logic [97:0] model(input logic signed [31:0] x, input logic signed [31:0] y,
                                          input logic signed [31:0] a);
        longint r;
        logic signed [31:0] xo, yo, ao;
        logic [1:0] q;
        r = longint'(a) % TWO;
        if (r < 0) r = r + TWO;
        xo = x;
        yo = y;
        if (r <= HALF) begin
            q = 2'd0; ao = 32'(r);
        end else if (r < THALF) begin
            q = 2'd1; ao = 32'(r - PI); xo = sat_neg(x); yo = sat_neg(y);
        end else begin
            q = 2'd2; ao = 32'(r - TWO);
        end
        return {q, ao, yo, xo};
    endfunction

    task automatic launch(input logic signed [31:0] x, input logic signed [31:0] y, input logic signed [31:0] a);
        x_in = x; y_in = y; angle_in = a; start = 1'b1;
        exp_q.push_back(model(x, y, a));
    endtask

    task automatic wait_done(input int stall_at, input int stall_len, input int poke_at, output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            if (c == 1) begin
                start = 1'b0;
                check_eq("busy_mid", busy, 1);
            end
            if (c == stall_at) enable = 1'b0;
            if (stall_len > 0 && c == stall_at + stall_len) enable = 1'b1;
            if (c == poke_at) begin
                start = 1'b1; x_in = $urandom; y_in = $urandom; angle_in = $urandom;
            end
            if (c == poke_at + 1) start = 1'b0;
        end
        if (lat < 0) check_eq("done_timeout", 0, 1);
    endtask

    task automatic finish_job(input int lat, input int exp_lat, input string tag);
        logic [97:0] e;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check_eq({tag, "_lat"}, lat, exp_lat);
            if (lat > 0) begin
                check_eq({tag, "_x"}, x_out, signed'(e[31:0]));
                check_eq({tag, "_y"}, y_out, signed'(e[63:32]));
                check_eq({tag, "_angle"}, angle_out, signed'(e[95:64]));
                check_eq({tag, "_quad"}, quadrant, e[97:96]);
            end
        end
    endtask

    task automatic check_done_drop(input string tag);
        @(negedge clock);
        check_eq(tag, done, 0);
    endtask

    task automatic expect_no_done(input int cycles, input string tag);
        int seen = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clock);
            if (done === 1'b1) seen++;
        end
        check_eq(tag, seen, 0);
    endtask

    logic signed [31:0] dx[10] = '{10188016, 10188016, 10188016, 5, 123, 1, 3, MIN32, 7, -9};
    logic signed [31:0] dy[10] = '{10188016, 10188016, 0, -7, 456, 2, 4, 100, MIN32, 11};
    logic signed [31:0] da[10] = '{118591152, 65883984, 81988912, -13176800, MIN32,
                                  26353589, 79060768, 52707179, 26353590, 79060767};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        reset = 1'b1; enable = 1'b1; start = 1'b0;
        x_in = '0; y_in = '0; angle_in = '0;
        repeat (3) @(negedge clock);
        check_eq("rst_x", x_out, 0);
        check_eq("rst_y", y_out, 0);
        check_eq("rst_angle", angle_out, 0);
        check_eq("rst_quad", quadrant, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 10; i++) begin
            launch(dx[i], dy[i], da[i]);
            wait_done(0, 0, 0, lat);
            finish_job(lat, 8, "dir");
            check_done_drop("dir_done_pulse");
        end

        for (int i = 0; i < 40; i++) begin
            launch(($urandom_range(0, 9) == 0) ? MIN32 : signed'($urandom),
                   ($urandom_range(0, 9) == 0) ? MIN32 : signed'($urandom),
                   signed'($urandom));
            wait_done(0, 0, 0, lat);
            finish_job(lat, 8, "rnd");
            if ($urandom_range(0, 1) == 1) check_done_drop("rnd_done_pulse");
        end

        launch(1000, -2000, 65883984);
        wait_done(0, 0, 3, lat);
        finish_job(lat, 8, "ignored_start");
        expect_no_done(12, "ignored_no_second_done");
        check_eq("ignored_idle", busy, 0);

        launch(42, 43, 81988912);
        wait_done(3, 4, 0, lat);
        finish_job(lat, 12, "stall");
        enable = 1'b0;
        @(negedge clock);
        check_eq("done_held_disabled", done, 1);
        enable = 1'b1;
        check_done_drop("done_drop_after_enable");

        launch(11, 22, 118591152);
        wait_done(0, 0, 0, lat);
        finish_job(lat, 8, "b2b_first");
        launch(-33, 44, -13176800);
        wait_done(0, 0, 0, lat);
        finish_job(lat, 8, "b2b_second");
        check_done_drop("b2b_done_pulse");

        launch(555, 666, 65883984);
        @(negedge clock); start = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_eq("midrst_x", x_out, 0);
        check_eq("midrst_y", y_out, 0);
        check_eq("midrst_angle", angle_out, 0);
        check_eq("midrst_quad", quadrant, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        reset = 1'b0;
        void'(exp_q.pop_back());
        expect_no_done(12, "midrst_no_done");

        launch(77, 88, 81988912);
        wait_done(0, 0, 0, lat);
        finish_job(lat, 8, "after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
